// File: rtl/scope_capture_ctrl.sv
// rtl/scope_capture_ctrl.sv - decimating circular capture with edge trigger and single-channel byte dump
module scope_capture_ctrl #(
    parameter int NUM_CH   = 3,
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 512,
    parameter int NUM_TRIG = 2,
    parameter int DEC_MAX  = 15
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic                                              smpl_vld,
    input  logic [NUM_CH*DATA_W-1:0]                          smpl_data,
    input  logic [NUM_TRIG-1:0]                               trig_in,
    input  logic [((NUM_TRIG > 1) ? $clog2(NUM_TRIG) : 1)-1:0] trig_sel,
    input  logic                                              trig_neg,
    input  logic                                              trig_en,
    input  logic [$clog2(DEPTH)-1:0]                          trig_pos,
    input  logic [3:0]                                        decimator,
    input  logic                                              clr_cap_done,
    output logic                                              cap_done,
    output logic                                              ram_we,
    output logic [$clog2(DEPTH)-1:0]                          ram_addr,
    output logic [NUM_CH*DATA_W-1:0]                          ram_wdata,
    output logic                                              ram_re,
    input  logic [NUM_CH*DATA_W-1:0]                          ram_rdata,
    input  logic                                              dump_start,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]     dump_ch,
    output logic [DATA_W-1:0]                                 dump_data,
    output logic                                              dump_vld,
    input  logic                                              dump_rdy,
    output logic                                              dump_done
);

    localparam int AW  = $clog2(DEPTH);
    localparam int TSW = (NUM_TRIG > 1) ? $clog2(NUM_TRIG) : 1;
    localparam int CSW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int DCW = (DEC_MAX > 0) ? DEC_MAX : 1;

    localparam logic [AW-1:0]  ONE_A      = AW'(1);
    localparam logic [AW-1:0]  MAX_A      = AW'(DEPTH - 1);
    localparam logic [AW:0]    ONE_C      = (AW+1)'(1);
    localparam logic [AW:0]    DEPTH_C    = (AW+1)'(DEPTH);
    localparam logic [AW:0]    LAST_C     = (AW+1)'(DEPTH - 1);
    localparam logic [DCW-1:0] ONE_D      = DCW'(1);
    localparam logic [3:0]     DEC_MAX_L  = 4'(DEC_MAX);
    localparam logic [TSW:0]   NUM_TRIG_L = (TSW+1)'(NUM_TRIG);
    localparam logic [CSW:0]   NUM_CH_L   = (CSW+1)'(NUM_CH);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PREFILL   = 3'd1,
        WAIT_TRIG = 3'd2,
        POST      = 3'd3,
        DONE      = 3'd4,
        DUMP      = 3'd5
    } state_t;

    state_t state, state_nx;

    logic [NUM_TRIG-1:0] trig_s1, trig_s2, trig_d;
    logic                sel_ok, trig_cur, trig_old, trig_edge;

    logic [AW-1:0]  tp, wr_ptr, cnt, pre_cnt;
    logic [DCW-1:0] dec_cnt, dec_lim;
    logic [DCW:0]   dec_span;
    logic [3:0]     dec_eff;
    logic           in_cap, pre_zero, smpl_take, store;

    logic [CSW-1:0]    dch;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       rd_cnt, acc_cnt;
    logic              pending, accept, out_free, rd_go, ch_ok;
    logic [DATA_W-1:0] lane;

    // Two-flop synchroniser on every trigger input plus one delay stage for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_s1 <= '0;
            trig_s2 <= '0;
            trig_d  <= '0;
        end else begin
            trig_s1 <= trig_in;
            trig_s2 <= trig_s1;
            trig_d  <= trig_s2;
        end
    end

    // Edge on the selected input; a per-input history avoids false edges when trig_sel changes
    always_comb begin
        sel_ok   = ({1'b0, trig_sel} < NUM_TRIG_L);
        trig_cur = 1'b0;
        trig_old = 1'b0;
        if (sel_ok) begin
            trig_cur = trig_s2[trig_sel];
            trig_old = trig_d[trig_sel];
        end
        trig_edge = trig_neg ? (trig_old & ~trig_cur) : (trig_cur & ~trig_old);
    end

    // A stored sample is every 2^dec-th strobe while capturing; a zero-length prefill stores nothing
    assign dec_eff   = (decimator > DEC_MAX_L) ? DEC_MAX_L : decimator;
    assign dec_span  = (DCW+1)'(1) << dec_eff;
    assign dec_lim   = dec_span[DCW-1:0] - ONE_D;
    assign pre_cnt   = MAX_A - tp;
    assign in_cap    = trig_en && (state == PREFILL || state == WAIT_TRIG || state == POST);
    assign pre_zero  = (state == PREFILL) && (pre_cnt == '0);
    assign smpl_take = in_cap && smpl_vld && !pre_zero;
    assign store     = smpl_take && (dec_cnt == dec_lim);

    // Dump read side: one read in flight, issued only when the output register can take its data
    assign ch_ok    = ({1'b0, dump_ch} < NUM_CH_L);
    assign accept   = dump_vld && dump_rdy;
    assign out_free = !dump_vld || dump_rdy;
    assign rd_go    = (state == DUMP) && !pending && out_free && (rd_cnt < DEPTH_C);
    assign lane     = ram_rdata[DATA_W*dch +: DATA_W];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state selection and the combinational RAM port / status outputs
    always_comb begin
        state_nx  = state;
        cap_done  = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        ram_re    = 1'b0;
        if (store) begin
            ram_we    = 1'b1;
            ram_addr  = wr_ptr;
            ram_wdata = smpl_data;
        end else if (rd_go) begin
            ram_re   = 1'b1;
            ram_addr = rd_ptr;
        end
        case (state)
            IDLE: begin
                if (trig_en) state_nx = PREFILL;
            end
            PREFILL: begin
                if (!trig_en)                          state_nx = IDLE;
                else if (pre_zero)                     state_nx = WAIT_TRIG;
                else if (store && cnt == pre_cnt - ONE_A) state_nx = WAIT_TRIG;
            end
            WAIT_TRIG: begin
                if (!trig_en)                state_nx = IDLE;
                else if (store && trig_edge) state_nx = (tp == '0) ? DONE : POST;
            end
            POST: begin
                if (!trig_en)                      state_nx = IDLE;
                else if (store && cnt == tp - ONE_A) state_nx = DONE;
            end
            DONE: begin
                cap_done = 1'b1;
                if (clr_cap_done)             state_nx = IDLE;
                else if (dump_start && ch_ok) state_nx = DUMP;
            end
            DUMP: begin
                cap_done = 1'b1;
                if (accept && acc_cnt == LAST_C) state_nx = DONE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Capture pointers/counters and the dump output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tp        <= '0;
            wr_ptr    <= '0;
            cnt       <= '0;
            dec_cnt   <= '0;
            dch       <= '0;
            rd_ptr    <= '0;
            rd_cnt    <= '0;
            acc_cnt   <= '0;
            pending   <= 1'b0;
            dump_data <= '0;
            dump_vld  <= 1'b0;
            dump_done <= 1'b0;
        end else begin
            dump_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (trig_en) begin
                        tp      <= trig_pos;
                        wr_ptr  <= '0;
                        cnt     <= '0;
                        dec_cnt <= '0;
                    end
                end
                PREFILL, WAIT_TRIG, POST: begin
                    if (smpl_take) dec_cnt <= store ? '0 : dec_cnt + ONE_D;
                    if (store) begin
                        wr_ptr <= wr_ptr + ONE_A;
                        cnt    <= (state == WAIT_TRIG) ? '0 : cnt + ONE_A;
                    end
                end
                DONE: begin
                    if (!clr_cap_done && dump_start) begin
                        if (ch_ok) begin
                            dch      <= dump_ch;
                            rd_ptr   <= wr_ptr;
                            rd_cnt   <= '0;
                            acc_cnt  <= '0;
                            pending  <= 1'b0;
                            dump_vld <= 1'b0;
                        end else begin
                            dump_done <= 1'b1;
                        end
                    end
                end
                DUMP: begin
                    pending <= rd_go;
                    if (rd_go) begin
                        rd_ptr <= rd_ptr + ONE_A;
                        rd_cnt <= rd_cnt + ONE_C;
                    end
                    if (pending) begin
                        dump_data <= lane;
                        dump_vld  <= 1'b1;
                    end else if (accept) begin
                        dump_vld <= 1'b0;
                    end
                    if (accept) begin
                        acc_cnt <= acc_cnt + ONE_C;
                        if (acc_cnt == LAST_C) dump_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_scope_capture_ctrl.sv
// tb/tb_scope_capture_ctrl.sv - table-driven bench for scope_capture_ctrl with a behavioural RAM
module tb_scope_capture_ctrl;

    localparam int NUM_CH   = 3;
    localparam int DATA_W   = 8;
    localparam int DEPTH    = 16;
    localparam int NUM_TRIG = 2;
    localparam int DEC_MAX  = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        smpl_vld;
    logic [23:0] smpl_data;
    logic [1:0]  trig_in;
    logic [0:0]  trig_sel;
    logic        trig_neg;
    logic        trig_en;
    logic [3:0]  trig_pos;
    logic [3:0]  decimator;
    logic        clr_cap_done;
    logic        cap_done;
    logic        ram_we;
    logic [3:0]  ram_addr;
    logic [23:0] ram_wdata;
    logic        ram_re;
    logic [23:0] ram_rdata;
    logic        dump_start;
    logic [1:0]  dump_ch;
    logic [7:0]  dump_data;
    logic        dump_vld;
    logic        dump_rdy;
    logic        dump_done;

    always #5 clk = ~clk;

    scope_capture_ctrl #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_TRIG(NUM_TRIG), .DEC_MAX(DEC_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n), .smpl_vld(smpl_vld), .smpl_data(smpl_data),
        .trig_in(trig_in), .trig_sel(trig_sel), .trig_neg(trig_neg), .trig_en(trig_en),
        .trig_pos(trig_pos), .decimator(decimator), .clr_cap_done(clr_cap_done),
        .cap_done(cap_done), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_re(ram_re), .ram_rdata(ram_rdata), .dump_start(dump_start), .dump_ch(dump_ch),
        .dump_data(dump_data), .dump_vld(dump_vld), .dump_rdy(dump_rdy), .dump_done(dump_done)
    );

    // Sample memory with one cycle read latency
    logic [23:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_re) ram_rdata <= mem[ram_addr];
    end

    typedef struct {
        int tp; int dec; int neg; int sel;
        int rise; int fall; int rise2; int noise;
        int ch; int rnd;
        int exp_wr; int exp_first; int exp_step;
    } vec_t;

    vec_t vecs [7];

    int total = 0;
    int bad   = 0;

    int         wr_n, nb, hold_err, done_n, vld_seen;
    int         last_waddr;
    int         beats [64];
    logic       stalled_prev;
    logic [7:0] held;

    function automatic logic [7:0] chan(input int ch, input int n);
        logic [7:0] b;
        b = 8'(n);
        case (ch)
            0:       return b;
            1:       return b + 8'd100;
            default: return ~b;
        endcase
    endfunction

    function automatic logic [23:0] sample(input int n);
        return {chan(2, n), chan(1, n), chan(0, n)};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Observe outputs between edges for the inputs just driven, then advance one cycle
    task automatic tick();
        #1;
        if (ram_we) begin
            wr_n++;
            last_waddr = int'(ram_addr);
        end
        if (dump_vld && dump_rdy) begin
            if (nb < 64) beats[nb] = int'(dump_data);
            nb++;
        end
        if (stalled_prev && (!dump_vld || dump_data !== held)) hold_err++;
        stalled_prev = dump_vld && !dump_rdy;
        held = dump_data;
        if (dump_done) done_n++;
        if (dump_vld) vld_seen++;
        @(negedge clk);
    endtask

    task automatic clear_log();
        wr_n = 0; nb = 0; hold_err = 0; done_n = 0; vld_seen = 0;
        stalled_prev = 1'b0; last_waddr = -1;
    endtask

    task automatic park(input vec_t v);
        trig_en = 1'b0; smpl_vld = 1'b0; dump_start = 1'b0; clr_cap_done = 1'b1;
        dump_rdy = 1'b1; trig_in = 2'b00;
        trig_sel = 1'(v.sel); trig_neg = 1'(v.neg);
        trig_pos = 4'(v.tp); decimator = 4'(v.dec);
        repeat (4) tick();
        clr_cap_done = 1'b0;
        clear_log();
    endtask

    task automatic do_capture(input vec_t v, input string tag);
        park(v);
        trig_en = 1'b1;
        tick();
        tick();
        for (int n = 0; n < 400 && !cap_done; n++) begin
            if (n == v.rise)  trig_in[v.sel] = 1'b1;
            if (n == v.fall)  trig_in[v.sel] = 1'b0;
            if (n == v.rise2) trig_in[v.sel] = 1'b1;
            if (n == v.noise) trig_in[1 - v.sel] = 1'b1;
            smpl_data = sample(n);
            smpl_vld  = 1'b1;
            tick();
        end
        smpl_vld = 1'b0;
        check({tag, "_cap_done"}, int'(cap_done), 1);
        check({tag, "_writes"}, wr_n, v.exp_wr);
    endtask

    task automatic do_dump(input vec_t v, input string tag);
        clear_log();
        dump_ch = 2'(v.ch); dump_start = 1'b1; dump_rdy = 1'b1;
        tick();
        dump_start = 1'b0;
        for (int c = 0; c < 300 && done_n == 0; c++) begin
            dump_rdy = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
        end
        dump_rdy = 1'b1;
        repeat (3) tick();
        check({tag, "_beats"}, nb, DEPTH);
        check({tag, "_done_cnt"}, done_n, 1);
        check({tag, "_hold"}, hold_err, 0);
        check({tag, "_cap_after"}, int'(cap_done), 1);
        for (int k = 0; k < DEPTH && k < nb; k++)
            check($sformatf("%s_beat%0d", tag, k), beats[k],
                  int'(chan(v.ch, v.exp_first + k * v.exp_step)));
    endtask

    initial begin
        //        tp  dec neg sel rise fall rise2 noise ch rnd  wr first step
        vecs[0] = '{4,  0,  0,  0,  18,  -1,  -1,  -1,  0, 0,  25,  9,   1};
        vecs[1] = '{0,  0,  0,  0,  18,  -1,  -1,  -1,  1, 0,  21,  5,   1};
        vecs[2] = '{15, 0,  0,  0,  18,  -1,  -1,  -1,  2, 0,  36,  20,  1};
        vecs[3] = '{4,  0,  1,  1,  10,  18,  -1,  6,   0, 0,  25,  9,   1};
        vecs[4] = '{7,  0,  0,  0,  30,  -1,  -1,  -1,  1, 1,  40,  24,  1};
        vecs[5] = '{2,  2,  0,  1,  53,  -1,  -1,  49,  0, 0,  16,  3,   4};
        vecs[6] = '{0,  15, 0,  0,  120, 122, 125, -1,  2, 1,  16,  7,   8};

        rst_n = 1'b0; smpl_vld = 1'b0; smpl_data = '0; trig_in = '0; trig_sel = '0;
        trig_neg = 1'b0; trig_en = 1'b0; trig_pos = '0; decimator = '0; clr_cap_done = 1'b0;
        dump_start = 1'b0; dump_ch = '0; dump_rdy = 1'b0;
        clear_log();
        repeat (2) @(negedge clk);
        #1;
        check("reset_outputs",
              int'({cap_done, ram_we, ram_addr, ram_wdata, ram_re, dump_data, dump_vld, dump_done}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("reset_cap_done", int'(cap_done), 0);

        for (int i = 0; i < 7; i++) begin
            do_capture(vecs[i], $sformatf("v%0d", i));
            do_dump(vecs[i], $sformatf("v%0d", i));
        end

        // Redump of the same capture, then an out-of-range channel and clear
        do_dump(vecs[6], "redump");
        clear_log();
        dump_ch = 2'd3; dump_start = 1'b1;
        tick();
        check("badch_done_early", done_n, 0);
        dump_start = 1'b0;
        tick();
        check("badch_done_next", done_n, 1);
        repeat (3) tick();
        check("badch_done_once", done_n, 1);
        check("badch_no_vld", vld_seen, 0);
        check("badch_cap_done", int'(cap_done), 1);
        clr_cap_done = 1'b1;
        tick();
        clr_cap_done = 1'b0;
        check("clr_cap_done", int'(cap_done), 0);
        clear_log();
        dump_ch = 2'd0; dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        repeat (4) tick();
        check("idle_dump_ignored", vld_seen + done_n, 0);

        // Abort from WAIT_TRIG: the strobe coinciding with trig_en falling is dropped
        park(vecs[1]);
        trig_en = 1'b1;
        tick();
        tick();
        for (int n = 0; n < 20; n++) begin
            smpl_data = sample(n); smpl_vld = 1'b1;
            tick();
        end
        check("abort_pre_writes", wr_n, 20);
        trig_en = 1'b0; smpl_data = sample(20);
        tick();
        check("abort_same_cycle", wr_n, 20);
        for (int n = 21; n < 31; n++) begin
            smpl_data = sample(n);
            trig_in[0] = (n >= 22);
            tick();
        end
        check("abort_no_writes", wr_n, 20);
        check("abort_no_cap_done", int'(cap_done), 0);
        trig_en = 1'b1; smpl_vld = 1'b0;
        tick();
        tick();
        smpl_data = sample(40); smpl_vld = 1'b1;
        tick();
        smpl_vld = 1'b0;
        check("restart_addr", last_waddr, 0);
        check("restart_writes", wr_n, 21);
        trig_en = 1'b0;

        // Asynchronous reset while a dump beat is stalled
        do_capture(vecs[0], "rst");
        clear_log();
        dump_ch = 2'd0; dump_start = 1'b1; dump_rdy = 1'b0;
        tick();
        dump_start = 1'b0;
        repeat (4) tick();
        check("rst_pre_vld", int'(dump_vld), 1);
        check("rst_pre_data", int'(dump_data), 9);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_dump",
              int'({cap_done, ram_we, ram_addr, ram_wdata, ram_re, dump_data, dump_vld, dump_done}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_log();
        dump_rdy = 1'b1;
        repeat (6) tick();
        check("rst_no_resume", vld_seen + done_n, 0);
        check("rst_cap_done", int'(cap_done), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1);
    end

endmodule
